// File: rtl/mandelbrot_pkg.sv
// Shared types and default widths for the Mandelbrot core and its frame dispatcher.
package mandelbrot_pkg;

    localparam int DEF_INTEGER_BITS    = 8;
    localparam int DEF_FRACTIONAL_BITS = 24;
    localparam int DEF_MAX_ITER_WIDTH  = 16;
    localparam int DEF_COL_WIDTH       = 11;
    localparam int DEF_ROW_WIDTH       = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_DRAIN = ST_DRAIN
    } disp_state_t;

endpackage

// File: rtl/mandelbrot_pixel_coord_gen.sv
// Raster-order pixel walker: column/row counters, x/y coordinate accumulators and
// first/last pixel flags. Frame geometry is captured on init and held for the frame.
module pixel_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_INTEGER_BITS + DEF_FRACTIONAL_BITS,
    parameter int COL_WIDTH  = DEF_COL_WIDTH,
    parameter int ROW_WIDTH  = DEF_ROW_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         init_i,
    input  logic                         advance_i,
    input  logic [COL_WIDTH-1:0]         width_i,
    input  logic [ROW_WIDTH-1:0]         height_i,
    input  logic signed [DATA_WIDTH-1:0] x_start_i,
    input  logic signed [DATA_WIDTH-1:0] y_start_i,
    input  logic signed [DATA_WIDTH-1:0] x_step_i,
    input  logic signed [DATA_WIDTH-1:0] y_step_i,
    output logic signed [DATA_WIDTH-1:0] x_o,
    output logic signed [DATA_WIDTH-1:0] y_o,
    output logic                         sof_o,
    output logic                         last_o
);

    localparam logic [COL_WIDTH-1:0] COL_ONE = {{(COL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ROW_WIDTH-1:0] ROW_ONE = {{(ROW_WIDTH-1){1'b0}}, 1'b1};

    logic [COL_WIDTH-1:0]         col_q, col_d, width_q, width_d;
    logic [ROW_WIDTH-1:0]         row_q, row_d, height_q, height_d;
    logic signed [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic signed [DATA_WIDTH-1:0] x_start_q, x_start_d, x_step_q, x_step_d, y_step_q, y_step_d;
    logic                         col_last;
    logic                         row_last;

    assign col_last = (col_q == (width_q - COL_ONE));
    assign row_last = (row_q == (height_q - ROW_ONE));

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        x_d       = x_q;
        y_d       = y_q;
        width_d   = width_q;
        height_d  = height_q;
        x_start_d = x_start_q;
        x_step_d  = x_step_q;
        y_step_d  = y_step_q;
        if (init_i) begin
            col_d     = '0;
            row_d     = '0;
            x_d       = x_start_i;
            y_d       = y_start_i;
            width_d   = width_i;
            height_d  = height_i;
            x_start_d = x_start_i;
            x_step_d  = x_step_i;
            y_step_d  = y_step_i;
        end else if (advance_i) begin
            // Row wrap reloads x from the latched start so rounding never accumulates across rows.
            if (!col_last) begin
                col_d = col_q + COL_ONE;
                x_d   = x_q + x_step_q;
            end else begin
                col_d = '0;
                x_d   = x_start_q;
                row_d = row_q + ROW_ONE;
                y_d   = y_q + y_step_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            width_q   <= '0;
            height_q  <= '0;
            x_start_q <= '0;
            x_step_q  <= '0;
            y_step_q  <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            y_q       <= y_d;
            width_q   <= width_d;
            height_q  <= height_d;
            x_start_q <= x_start_d;
            x_step_q  <= x_step_d;
            y_step_q  <= y_step_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign sof_o  = (col_q == '0) && (row_q == '0);
    assign last_o = col_last && row_last;

endmodule

// File: rtl/mandelbrot_dispatcher.sv
// Frame-level initiator for a single mandelbrotCore: issues one pixel at a time and
// streams iteration counts out through a one-entry valid/ready register.
//
//   state | meaning
//   IDLE  | waiting for start_i; zero-sized frames complete here
//   ISSUE | core_start_o high for the current pixel
//   WAIT  | waiting for core done and a free output slot
//   DRAIN | last result captured, waiting for it to be accepted
module mandelbrot_dispatcher
    import mandelbrot_pkg::*;
#(
    parameter int INTEGER_BITS    = DEF_INTEGER_BITS,
    parameter int FRACTIONAL_BITS = DEF_FRACTIONAL_BITS,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = DEF_MAX_ITER_WIDTH,
    parameter int COL_WIDTH       = DEF_COL_WIDTH,
    parameter int ROW_WIDTH       = DEF_ROW_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [COL_WIDTH-1:0]         width_i,
    input  logic [ROW_WIDTH-1:0]         height_i,
    input  logic signed [DATA_WIDTH-1:0] x_start_i,
    input  logic signed [DATA_WIDTH-1:0] y_start_i,
    input  logic signed [DATA_WIDTH-1:0] x_step_i,
    input  logic signed [DATA_WIDTH-1:0] y_step_i,
    input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
    output logic                         core_start_o,
    output logic signed [DATA_WIDTH-1:0] core_x0_o,
    output logic signed [DATA_WIDTH-1:0] core_y0_o,
    output logic [MAX_ITER_WIDTH-1:0]    core_max_iter_o,
    input  logic [MAX_ITER_WIDTH-1:0]    core_iter_i,
    input  logic                         core_done_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [MAX_ITER_WIDTH-1:0]    res_iter_o,
    output logic                         res_sof_o,
    output logic                         res_last_o,
    output logic                         busy_o,
    output logic                         frame_done_o
);

    disp_state_t                 state_q, state_d;
    logic [MAX_ITER_WIDTH-1:0]   max_iter_q, max_iter_d;
    logic                        core_start_q, core_start_d;
    logic                        frame_done_q, frame_done_d;
    logic                        res_valid_q, res_valid_d;
    logic [MAX_ITER_WIDTH-1:0]   res_iter_q, res_iter_d;
    logic                        res_sof_q, res_sof_d;
    logic                        res_last_q, res_last_d;
    logic                        gen_init;
    logic                        gen_advance;
    logic                        pix_sof;
    logic                        pix_last;
    logic                        slot_free;
    logic                        capture;

    pixel_coord_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .COL_WIDTH  (COL_WIDTH),
        .ROW_WIDTH  (ROW_WIDTH)
    ) u_coord (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .init_i     (gen_init),
        .advance_i  (gen_advance),
        .width_i    (width_i),
        .height_i   (height_i),
        .x_start_i  (x_start_i),
        .y_start_i  (y_start_i),
        .x_step_i   (x_step_i),
        .y_step_i   (y_step_i),
        .x_o        (core_x0_o),
        .y_o        (core_y0_o),
        .sof_o      (pix_sof),
        .last_o     (pix_last)
    );

    // A full slot that is being accepted this cycle can take a new result on the same edge.
    assign slot_free = !res_valid_q || res_ready_i;
    assign capture   = (state_q == S_WAIT) && core_done_i && slot_free;

    always_comb begin
        state_d      = state_q;
        max_iter_d   = max_iter_q;
        core_start_d = 1'b0;
        frame_done_d = 1'b0;
        res_valid_d  = res_valid_q;
        res_iter_d   = res_iter_q;
        res_sof_d    = res_sof_q;
        res_last_d   = res_last_q;
        gen_init     = 1'b0;
        gen_advance  = 1'b0;

        if (res_valid_q && res_ready_i) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    gen_init   = 1'b1;
                    max_iter_d = max_iter_i;
                    if ((width_i == '0) || (height_i == '0)) begin
                        frame_done_d = 1'b1;
                    end else begin
                        state_d      = S_ISSUE;
                        core_start_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (capture) begin
                    res_valid_d = 1'b1;
                    res_iter_d  = core_iter_i;
                    res_sof_d   = pix_sof;
                    res_last_d  = pix_last;
                    if (pix_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        gen_advance  = 1'b1;
                        state_d      = S_ISSUE;
                        core_start_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (res_valid_q && res_ready_i) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            max_iter_q   <= '0;
            core_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_iter_q   <= '0;
            res_sof_q    <= 1'b0;
            res_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            max_iter_q   <= max_iter_d;
            core_start_q <= core_start_d;
            frame_done_q <= frame_done_d;
            res_valid_q  <= res_valid_d;
            res_iter_q   <= res_iter_d;
            res_sof_q    <= res_sof_d;
            res_last_q   <= res_last_d;
        end
    end

    assign core_start_o    = core_start_q;
    assign core_max_iter_o = max_iter_q;
    assign res_valid_o     = res_valid_q;
    assign res_iter_o      = res_iter_q;
    assign res_sof_o       = res_sof_q;
    assign res_last_o      = res_last_q;
    assign busy_o          = (state_q != S_IDLE);
    assign frame_done_o    = frame_done_q;

endmodule
